des_job_scheduler: RTL and testbench

DES_JOB_SCHEDULER -- requirements
Module: des_job_scheduler

---
 rtl/des_job_scheduler_if.sv | 38 +++
 rtl/des_job_scheduler.sv | 156 +++++++++++++++
 tb/tb_des_job_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/des_job_scheduler_if.sv
// Requester, response and core-side signal bundle for des_job_scheduler.
// slave is the scheduler view; master is the requester/core environment.
interface des_job_scheduler_if;
   logic [1:0]   req_valid;
   logic [1:0]   req_mode;
   logic [127:0] req_key;
   logic [127:0] req_text;
   logic [1:0]   req_ready;
   logic [1:0]   rsp_valid;
   logic [63:0]  rsp_text;
   logic         rsp_err;
   logic         core_start_encrypt;
   logic         core_start_decrypt;
   logic         core_mode;
   logic [63:0]  core_key;
   logic [63:0]  core_text;
   logic         core_done_encrypt;
   logic         core_done_decrypt;
   logic [63:0]  core_text_out;
   logic         busy;
   logic         owner;

   modport slave (
      input  req_valid, req_mode, req_key, req_text,
      input  core_done_encrypt, core_done_decrypt, core_text_out,
      output req_ready, rsp_valid, rsp_text, rsp_err,
      output core_start_encrypt, core_start_decrypt,
      output core_mode, core_key, core_text, busy, owner
   );

   modport master (
      output req_valid, req_mode, req_key, req_text,
      output core_done_encrypt, core_done_decrypt, core_text_out,
      input  req_ready, rsp_valid, rsp_text, rsp_err,
      input  core_start_encrypt, core_start_decrypt,
      input  core_mode, core_key, core_text, busy, owner
   );
endinterface

// File: rtl/des_job_scheduler.sv
// Two-requester round-robin job scheduler in front of a single DES core.
// One job in flight; timeout abort; waits for core done to clear before replying.
module des_job_scheduler #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   des_job_scheduler_if.slave   bus
);

   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT_DONE, S_DRAIN, S_RESPOND
   } state_t;

   state_t        r_state, w_state;
   logic          r_rr, w_rr;
   logic          r_owner, w_owner;
   logic [CW-1:0] r_cnt, w_cnt;
   logic [1:0]    r_ready, w_ready;
   logic [1:0]    r_rsp_valid, w_rsp_valid;
   logic [63:0]   r_rsp_text, w_rsp_text;
   logic          r_rsp_err, w_rsp_err;
   logic          r_start_enc, w_start_enc;
   logic          r_start_dec, w_start_dec;
   logic          r_mode, w_mode;
   logic [63:0]   r_key, w_key;
   logic [63:0]   r_text, w_text;
   logic          w_grant;
   logic          w_match;
   logic [6:0]    w_base;

   // Round-robin pick: pointer breaks ties, a lone request always wins
   always_comb begin
      w_grant = 1'b0;
      if (&bus.req_valid)
         w_grant = r_rr;
      else if (bus.req_valid[1])
         w_grant = 1'b1;
   end

   assign w_base  = {w_grant, 6'd0};
   assign w_match = r_mode ? bus.core_done_decrypt
                           : bus.core_done_encrypt;

   // Next-state and next-register values; outputs are all registered
   always_comb begin
      w_state     = r_state;
      w_rr        = r_rr;
      w_owner     = r_owner;
      w_cnt       = r_cnt;
      w_ready     = 2'b00;
      w_rsp_valid = 2'b00;
      w_rsp_text  = r_rsp_text;
      w_rsp_err   = r_rsp_err;
      w_start_enc = r_start_enc;
      w_start_dec = r_start_dec;
      w_mode      = r_mode;
      w_key       = r_key;
      w_text      = r_text;
      unique case (r_state)
         S_IDLE: begin
            if (|bus.req_valid) begin
               w_ready     = 2'(1) << w_grant;
               w_owner     = w_grant;
               w_mode      = bus.req_mode[w_grant];
               w_key       = bus.req_key[w_base +: 64];
               w_text      = bus.req_text[w_base +: 64];
               w_start_enc = ~bus.req_mode[w_grant];
               w_start_dec = bus.req_mode[w_grant];
               w_state     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_cnt   = '0;
            w_state = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (w_match) begin
               w_rsp_text  = bus.core_text_out;
               w_rsp_err   = 1'b0;
               w_start_enc = 1'b0;
               w_start_dec = 1'b0;
               w_state     = S_DRAIN;
            end else if (r_cnt == C_LAST) begin
               w_rsp_text  = '0;
               w_rsp_err   = 1'b1;
               w_start_enc = 1'b0;
               w_start_dec = 1'b0;
               w_state     = S_DRAIN;
            end else if (r_cnt != '1) begin
               w_cnt = r_cnt + 1'b1;
            end
         end
         S_DRAIN: begin
            if (!bus.core_done_encrypt && !bus.core_done_decrypt) begin
               w_rsp_valid = 2'(1) << r_owner;
               w_state     = S_RESPOND;
            end
         end
         S_RESPOND: begin
            w_rr    = ~r_owner;
            w_state = S_IDLE;
         end
         default: w_state = S_IDLE;
      endcase
   end

   // State and datapath registers; reset drops the core start at once
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_rr        <= 1'b0;
         r_owner     <= 1'b0;
         r_cnt       <= '0;
         r_ready     <= 2'b00;
         r_rsp_valid <= 2'b00;
         r_rsp_text  <= '0;
         r_rsp_err   <= 1'b0;
         r_start_enc <= 1'b0;
         r_start_dec <= 1'b0;
         r_mode      <= 1'b0;
         r_key       <= '0;
         r_text      <= '0;
      end else begin
         r_state     <= w_state;
         r_rr        <= w_rr;
         r_owner     <= w_owner;
         r_cnt       <= w_cnt;
         r_ready     <= w_ready;
         r_rsp_valid <= w_rsp_valid;
         r_rsp_text  <= w_rsp_text;
         r_rsp_err   <= w_rsp_err;
         r_start_enc <= w_start_enc;
         r_start_dec <= w_start_dec;
         r_mode      <= w_mode;
         r_key       <= w_key;
         r_text      <= w_text;
      end
   end

   assign bus.req_ready          = r_ready;
   assign bus.rsp_valid          = r_rsp_valid;
   assign bus.rsp_text           = r_rsp_text;
   assign bus.rsp_err            = r_rsp_err;
   assign bus.core_start_encrypt = r_start_enc;
   assign bus.core_start_decrypt = r_start_dec;
   assign bus.core_mode          = r_mode;
   assign bus.core_key           = r_key;
   assign bus.core_text          = r_text;
   assign bus.busy               = (r_state != S_IDLE);
   assign bus.owner              = r_owner;

endmodule

// File: tb/tb_des_job_scheduler.sv
// Scoreboard bench for des_job_scheduler with a behavioural core model.
// Requester threads push expectations; a negedge monitor pops and compares.
module tb_des_job_scheduler;

   localparam int TO = 8;

   typedef struct packed {
      logic        owner;
      logic [63:0] text;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic        rv0 = 1'b0, rv1 = 1'b0;
   logic        m0 = 1'b0, m1 = 1'b0;
   logic [63:0] k0 = '0, k1 = '0, t0 = '0, t1 = '0;

   logic        de = 1'b0, dd = 1'b0;
   logic [63:0] tout = '0;
   int          lat = 3;
   int          hold = 1;
   bit          never_done = 1'b0;
   bit          wrong = 1'b0;

   exp_t exp_q[$];
   bit   gnt_q[$];

   int total = 0;
   int bad = 0;
   int start_run = 0;
   int last_start = 0;
   int drain_run = 0;
   int last_drain = 0;

   des_job_scheduler_if bus ();

   assign bus.req_valid     = {rv1, rv0};
   assign bus.req_mode      = {m1, m0};
   assign bus.req_key       = {k1, k0};
   assign bus.req_text      = {t1, t0};
   assign bus.core_done_encrypt = de;
   assign bus.core_done_decrypt = dd;
   assign bus.core_text_out = tout;

   des_job_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] des_f(logic mode, logic [63:0] key,
                                         logic [63:0] text);
      if (key == 64'h133457799BBCDFF1 && !mode
          && text == 64'h0123456789ABCDEF)
         return 64'h85E813540F0AB405;
      if (key == 64'h133457799BBCDFF1 && mode
          && text == 64'h85E813540F0AB405)
         return 64'h0123456789ABCDEF;
      return text ^ key;
   endfunction

   task automatic push_exp(bit o, logic [63:0] t, bit e);
      exp_t x;
      x.owner = o;
      x.text  = t;
      x.err   = e;
      exp_q.push_back(x);
   endtask

   // Core model: done after lat start-high cycles, held hold cycles after start falls
   initial begin
      int mcnt;
      int hcnt;
      mcnt = 0;
      hcnt = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            de = 0; dd = 0; mcnt = 0; hcnt = 0;
         end else if (bus.core_start_encrypt || bus.core_start_decrypt) begin
            hcnt = 0;
            mcnt++;
            if (wrong && mcnt == 2) begin
               de = bus.core_start_decrypt;
               dd = bus.core_start_encrypt;
               tout = 64'hDEADBEEFDEADBEEF;
            end else if (!never_done && mcnt >= lat) begin
               de = bus.core_start_encrypt;
               dd = bus.core_start_decrypt;
               tout = des_f(bus.core_mode, bus.core_key, bus.core_text);
            end else begin
               de = 0; dd = 0;
            end
         end else if (de || dd) begin
            hcnt++;
            if (hcnt >= hold) begin
               de = 0; dd = 0;
            end
         end else begin
            mcnt = 0;
            hcnt = 0;
         end
      end
   end

   // Monitor: scoreboard pops on grants and responses, plus timing tallies
   initial begin
      exp_t e;
      bit   g;
      forever begin
         @(negedge clk);
         chk("one_start",
             128'(bus.core_start_encrypt & bus.core_start_decrypt), 128'(0));
         if (bus.req_ready != 2'b00) begin
            if (gnt_q.size() == 0) begin
               total++; bad++;
               $display("FAIL grant_unexpected: got %b expected none",
                        bus.req_ready);
            end else begin
               g = gnt_q.pop_front();
               chk("grant", 128'(bus.req_ready), 128'(2'(1) << g));
            end
         end
         if (bus.rsp_valid != 2'b00) begin
            last_drain = drain_run;
            drain_run = 0;
            chk("rsp_after_done", 128'({de, dd}), 128'(0));
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL rsp_unexpected: got %b expected none",
                        bus.rsp_valid);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_owner", 128'(bus.rsp_valid), 128'(2'(1) << e.owner));
               chk("rsp_text", 128'(bus.rsp_text), 128'(e.text));
               chk("rsp_err", 128'(bus.rsp_err), 128'(e.err));
            end
         end else if (bus.busy && !bus.core_start_encrypt
                      && !bus.core_start_decrypt) begin
            drain_run++;
         end
         if (bus.core_start_encrypt || bus.core_start_decrypt) begin
            start_run++;
         end else if (start_run != 0) begin
            last_start = start_run;
            start_run = 0;
         end
      end
   end

   task automatic req(int i, bit mode, logic [63:0] key, logic [63:0] text);
      int n;
      n = 0;
      if (i == 0) begin
         m0 = mode; k0 = key; t0 = text; rv0 = 1'b1;
      end else begin
         m1 = mode; k1 = key; t1 = text; rv1 = 1'b1;
      end
      forever begin
         @(negedge clk);
         if (bus.req_ready[i]) break;
         n++;
         if (n > 300) begin
            total++; bad++;
            $display("FAIL req_timeout: requester %0d got no ready expected one", i);
            break;
         end
      end
      if (i == 0) begin
         rv0 = 1'b0; k0 = {$urandom, $urandom}; t0 = {$urandom, $urandom};
      end else begin
         rv1 = 1'b0; k1 = {$urandom, $urandom}; t1 = {$urandom, $urandom};
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || gnt_q.size() != 0 || bus.busy)
             && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) begin
         total++; bad++;
         $display("FAIL wait_done: got busy after %0d cycles expected idle", n);
      end
      @(negedge clk);
   endtask

   task automatic chk_reset(string tag);
      chk({tag, "_ctrl"},
          128'({bus.req_ready, bus.rsp_valid, bus.rsp_err,
                bus.core_start_encrypt, bus.core_start_decrypt,
                bus.core_mode, bus.busy, bus.owner}), 128'(0));
      chk({tag, "_data"}, {bus.rsp_text, bus.core_key}, 128'(0));
      chk({tag, "_text"}, 128'(bus.core_text), 128'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset("reset");
      rst = 1'b1;
      @(negedge clk);

      // DES encrypt on requester 0
      gnt_q.push_back(1'b0);
      push_exp(1'b0, 64'h85E813540F0AB405, 1'b0);
      req(0, 1'b0, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF);
      wait_done();
      chk("enc_start_len", 128'(last_start), 128'(3));
      chk("enc_drain_len", 128'(last_drain), 128'(1));

      // DES decrypt on requester 1
      gnt_q.push_back(1'b1);
      push_exp(1'b1, 64'h0123456789ABCDEF, 1'b0);
      req(1, 1'b1, 64'h133457799BBCDFF1, 64'h85E813540F0AB405);
      wait_done();

      // Both requesters continuously valid: alternate 0,1,0,1
      gnt_q.push_back(1'b0);
      gnt_q.push_back(1'b1);
      gnt_q.push_back(1'b0);
      gnt_q.push_back(1'b1);
      push_exp(1'b0, 64'hFEDC45677654CDEF, 1'b0);
      push_exp(1'b1, 64'h11111111111111EE, 1'b0);
      push_exp(1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0);
      push_exp(1'b1, 64'h0000000000000001, 1'b0);
      fork
         begin
            req(0, 1'b0, 64'hFFFF0000FFFF0000, 64'h0123456789ABCDEF);
            req(0, 1'b0, 64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555);
         end
         begin
            req(1, 1'b1, 64'h00000000000000FF, 64'h1111111111111111);
            req(1, 1'b0, 64'h0000000000000001, 64'h0000000000000000);
         end
      join
      wait_done();

      // Core never finishes: timeout after 8 wait cycles
      never_done = 1'b1;
      gnt_q.push_back(1'b0);
      push_exp(1'b0, 64'h0, 1'b1);
      req(0, 1'b0, 64'h0123012301230123, 64'h4567456745674567);
      wait_done();
      chk("timeout_start_len", 128'(last_start), 128'(TO + 1));
      never_done = 1'b0;

      // Core keeps done high 3 cycles after start falls
      hold = 3;
      gnt_q.push_back(1'b1);
      push_exp(1'b1, 64'h0F0F0F0FF0F0F0F0, 1'b0);
      req(1, 1'b1, 64'h0F0F0F0F0F0F0F0F, 64'h00000000FFFFFFFF);
      wait_done();
      chk("drain_len", 128'(last_drain), 128'(3));
      hold = 1;

      // Spurious non-matching done is ignored
      wrong = 1'b1;
      gnt_q.push_back(1'b0);
      push_exp(1'b0, 64'h1234567812345678, 1'b0);
      req(0, 1'b1, 64'h1234567800000000, 64'h0000000012345678);
      wait_done();
      wrong = 1'b0;

      // Reset in the middle of a job from requester 1
      never_done = 1'b1;
      gnt_q.push_back(1'b1);
      req(1, 1'b0, 64'h5A5A5A5A5A5A5A5A, 64'h0102030405060708);
      repeat (3) @(negedge clk);
      chk("pre_reset_start", 128'(bus.core_start_encrypt), 128'(1));
      #1 rst = 1'b0;
      #1 chk_reset("midjob_reset");
      repeat (3) @(negedge clk);
      rst = 1'b1;
      never_done = 1'b0;
      @(negedge clk);
      gnt_q.push_back(1'b0);
      gnt_q.push_back(1'b1);
      push_exp(1'b0, 64'hCAFEBABE00000000, 1'b0);
      push_exp(1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b0);
      fork
         req(0, 1'b0, 64'h0, 64'hCAFEBABE00000000);
         req(1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h0);
      join
      wait_done();

      chk("exp_q_empty", 128'(exp_q.size()), 128'(0));
      chk("gnt_q_empty", 128'(gnt_q.size()), 128'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
